// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, flag bit positions, stage records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // Bit positions inside flags = {overflow, underflow, invalid}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INV = 0;

  // Control record carried alongside the datapath from S1 to S3.
  typedef struct packed {
    logic sign;     // effective sign of the larger-magnitude operand
    logic eff_sub;  // operands have opposite effective signs
    logic spc;      // special-value result replaces the datapath result
    logic spc_nan;  // special result is the quiet NaN
    logic spc_sign; // sign of a special infinity result
  } ctl_t;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; count = WIDTH when the input is all zeros.
// Latency: combinational.
// Backpressure: n/a.
// Ports: din (value to scan from the MSB), count (number of leading zeros).
module fpu_lzc #(
  parameter  int WIDTH = 27,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/faddsub_pipe.sv
// Pipelined IEEE-style floating-point add/subtract, round-to-nearest-even, DAZ/FTZ.
// Latency: 3 cycles from acceptance to result, 1 op/cycle sustained.
// Backpressure: in_ready = out_ready || !out_valid; the whole pipe freezes when in_ready is low.
// Ports: clk/reset (async active-low); in_valid/in_ready + op1/op2/sub input handshake;
//        out_valid/out_ready + result/flags {overflow, underflow, invalid} output handshake.
// Build option FADDSUB_SPECIALS_EN: decode Inf/NaN operands; otherwise exponent all-ones is
// an ordinary exponent and the invalid flag is never raised.
module faddsub_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int XW = MAN_W + 4;             // hidden bit + mantissa + guard/round/sticky
  localparam int SW = XW + 1;                // sum with carry-out
  localparam int CW = $clog2(XW + 1);        // leading-zero count width
  localparam int EW = EXP_W + CW + 1;        // signed exponent, wide enough for any lz
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------- S1: align
  logic             a_sgn, b_sgn, swap, big_sgn;
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, sml_exp, exp_diff;
  logic [MAN_W-1:0] a_man, b_man, big_man, sml_man;
  logic [XW-1:0]    big_x, sml_x, sml_sh, sml_lost, sml_al;
  ctl_t             ctl_in;
`ifdef FADDSUB_SPECIALS_EN
  logic             a_inf, a_nan, b_inf, b_nan;
`endif

  always_comb begin
    a_sgn = op1[W-1];
    b_sgn = op2[W-1] ^ sub;
    a_exp = op1[W-2:MAN_W];
    b_exp = op2[W-2:MAN_W];
    // Denormals are flushed: exponent 0 means a signed zero.
    a_man = (a_exp == '0) ? '0 : op1[MAN_W-1:0];
    b_man = (b_exp == '0) ? '0 : op2[MAN_W-1:0];

    swap    = {b_exp, b_man} > {a_exp, a_man};
    big_sgn = swap ? b_sgn : a_sgn;
    big_exp = swap ? b_exp : a_exp;
    big_man = swap ? b_man : a_man;
    sml_exp = swap ? a_exp : b_exp;
    sml_man = swap ? a_man : b_man;

    exp_diff = big_exp - sml_exp;
    big_x    = {|big_exp, big_man, 3'b000};
    sml_x    = {|sml_exp, sml_man, 3'b000};
    sml_sh   = sml_x >> exp_diff;
    sml_lost = sml_x & ~({XW{1'b1}} << exp_diff);
    // Bits shifted past the sticky position are ORed into it; a shift that
    // would push the hidden bit past round leaves only a sticky bit.
    if (int'(exp_diff) >= MAN_W + 3) sml_al = {{(XW-1){1'b0}}, |sml_x};
    else                             sml_al = {sml_sh[XW-1:1], sml_sh[0] | (|sml_lost)};

    ctl_in         = '0;
    ctl_in.sign    = big_sgn;
    ctl_in.eff_sub = a_sgn ^ b_sgn;
`ifdef FADDSUB_SPECIALS_EN
    a_inf = (a_exp == '1) && (op1[MAN_W-1:0] == '0);
    a_nan = (a_exp == '1) && (op1[MAN_W-1:0] != '0);
    b_inf = (b_exp == '1) && (op2[MAN_W-1:0] == '0);
    b_nan = (b_exp == '1) && (op2[MAN_W-1:0] != '0);
    ctl_in.spc      = a_inf | a_nan | b_inf | b_nan;
    ctl_in.spc_nan  = a_nan | b_nan | (a_inf & b_inf & (a_sgn != b_sgn));
    ctl_in.spc_sign = a_inf ? a_sgn : b_sgn;
`endif
  end

  logic             v1;
  ctl_t             c1;
  logic [EXP_W-1:0] e1;
  logic [XW-1:0]    xb1, xs1;

  // ---------------------------------------------------------------- S2: add + lzc
  // Larger magnitude is always first, so the difference never goes negative.
  logic [SW-1:0] sum_n;
  logic [CW-1:0] lz_n;

  assign sum_n = c1.eff_sub ? ({1'b0, xb1} - {1'b0, xs1}) : ({1'b0, xb1} + {1'b0, xs1});

  fpu_lzc #(.WIDTH(XW)) u_lzc (
    .din   (sum_n[XW-1:0]),
    .count (lz_n)
  );

  logic             v2;
  ctl_t             c2;
  logic [EXP_W-1:0] e2;
  logic [SW-1:0]    sum2;
  logic [CW-1:0]    lz2;

  // ---------------------------------------------------------------- S3: normalise, round, pack
  logic signed [EW-1:0] exp_n, exp_r;
  logic [XW-1:0]        norm;
  logic                 rnd_up;
  logic [MAN_W:0]       frac_r;   // {rounding carry-out, fraction}
  logic [W-1:0]         res_n;
  logic [2:0]           flg_n;

  always_comb begin
    if (sum2[SW-1]) begin
      norm  = {sum2[SW-1:2], |sum2[1:0]};
      exp_n = EW'(e2) + EW'(1);
    end else begin
      norm  = sum2[XW-1:0] << lz2;
      exp_n = EW'(e2) - EW'(lz2);
    end

    // norm = {hidden, fraction, G, R, S}
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r = {1'b0, norm[XW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
    // A carry-out leaves the fraction all-zero and doubles the value.
    exp_r  = exp_n + EW'(frac_r[MAN_W]);

    res_n = {c2.sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flg_n = '0;
    if (c2.spc) begin
      res_n           = c2.spc_nan ? QNAN : {c2.spc_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n[FLAG_INV] = c2.spc_nan;
    end else if (!norm[XW-1]) begin
      // Exact zero: cancellation gives +0, only like-signed zeros keep the sign.
      res_n = {c2.sign & ~c2.eff_sub, {(W-1){1'b0}}};
    end else if (exp_r < EXP_ONE) begin
      res_n           = {c2.sign, {(W-1){1'b0}}};
      flg_n[FLAG_UNF] = 1'b1;
    end else if (exp_r >= EXP_INF) begin
      res_n           = {c2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n[FLAG_OVF] = 1'b1;
    end
  end

  // ---------------------------------------------------------------- pipeline control
  assign in_ready = out_ready || !out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (in_ready) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        result <= res_n;
        flags  <= flg_n;
      end
    end
  end

  // Datapath payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      c1   <= ctl_in;
      e1   <= big_exp;
      xb1  <= big_x;
      xs1  <= sml_al;
      c2   <= c1;
      e2   <= e1;
      sum2 <= sum_n;
      lz2  <= lz_n;
    end
  end

endmodule

// File: tb/tb_faddsub_pipe.sv
// Directed bench for faddsub_pipe: vector table (one at a time and streamed),
// backpressure sequence and mid-stream reset.
module tb_faddsub_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  faddsub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.r = r; v.f = f;
    vt.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    op1 = v.a;
    op2 = v.b;
    sub = v.s;
  endtask

  // One isolated op: checks exact latency, result and flags.
  task automatic run_one(input int i);
    int lat;
    @(negedge clk);
    drive(vt[i]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", i), lat, 3);
    check($sformatf("v%0d result", i), result, vt[i].r);
    check($sformatf("v%0d flags", i), flags, vt[i].f);
  endtask

  // Whole table back-to-back with out_ready high: one result per cycle, in order.
  task automatic stream_all();
    int n, got, first, last;
    n = vt.size(); got = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          drive(vt[i]);
          in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < n + 20 && got < n; c++) begin
          @(negedge clk);
          if (out_valid) begin
            check($sformatf("stream v%0d result", got), result, vt[got].r);
            check($sformatf("stream v%0d flags", got), flags, vt[got].f);
            if (first < 0) first = c;
            last = c;
            got++;
          end
        end
      end
    join
    check("stream count", got, n);
    check("stream gap-free", last - first, n - 1);
  endtask

  // Four ops offered back-to-back while out_ready is low for the first 5 cycles.
  task automatic backpressure();
    int tx, rx, blk_at;
    tx = 0; rx = 0; blk_at = -1;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (tx < 4);
      if (tx < 4) drive(vt[tx]);
      #1;
      if (in_valid && !in_ready && blk_at < 0) blk_at = tx;
      if (out_valid && !out_ready)
        check($sformatf("stall hold c%0d", c), result, vt[rx].r);
      if (out_valid && out_ready) begin
        check($sformatf("bp out%0d result", rx), result, vt[rx].r);
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp accepts before in_ready fell", blk_at, 3);
    check("bp accepted", tx, 4);
    check("bp retired", rx, 4);
  endtask

  task automatic reset_mid_stream();
    int cnt;
    @(negedge clk);
    drive(vt[0]);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", out_valid, 0);
    check("mid reset in_ready", in_ready, 1);
    check("mid reset result", result, 0);
    check("mid reset flags", flags, 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("handshakes after reset", cnt, 0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset result", result, 0);
    check("reset flags", flags, 0);
    reset = 1'b1;

    add(1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000); // 1+1
    add(1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000); // 1-1 -> +0
    add(1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000); // tie, even stays
    add(1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000); // tie, odd rounds up
    add(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100); // overflow
    add(1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 3'b010); // underflow, -0
    add(1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000); // -0 + -0
    add(1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000); // denormal flushed
    add(1'b0, 32'h00400000, 32'h00400000, 32'h00000000, 3'b000); // two denormals
    add(1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000); // 3-1
    add(1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000); // x + -x -> +0
    add(1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000); // 1-2
    add(1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 3'b000); // sticky-only shift
    add(1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 3'b000); // above half rounds up
    add(1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100); // exp reaches all-ones
    add(1'b0, 32'hC0000000, 32'hC0000000, 32'hC0800000, 3'b000); // -2 + -2
    add(1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 3'b000); // round carry-out
    add(1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 3'b010); // result exp 0
    add(1'b0, 32'h00800000, 32'h00000000, 32'h00800000, 3'b000); // smallest normal kept
`ifdef FADDSUB_SPECIALS_EN
    add(1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001); // inf - inf
    add(1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001); // NaN in
    add(1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000); // inf + finite
`else
    add(1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b100); // all-ones exp is ordinary
`endif

    for (int i = 0; i < vt.size(); i++) run_one(i);
    stream_all();
    backpressure();
    reset_mid_stream();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
